fb_write_arbiter: RTL
=====================

Name: fb_write_arbiter

Overview:
Arbitrates the single frame_buffer write port between N pixel-writing requesters (fill_drawer, line_drawer, symbol_drawer by default). Each requester uses a valid/ready handshake, which replaces the wired-OR merge of write buses. Arbitration is round-robin with bounded bursts. The block sits between the drawers and frame_buffer in the clk_25M175 domain, and its output stage is registered.

Parameters:
N, 3, number of requesters (index 0 = fill, 1 = line, 2 = symbol)
HOR_ACTIVE_PIXELS, 640, active pixels per line
VER_ACTIVE_PIXELS, 480, active lines
ADDR_WIDTH, $clog2(HOR_ACTIVE_PIXELS*VER_ACTIVE_PIXELS), frame buffer address width (localparam)
BURST_LEN, 16, maximum consecutive transfers granted to one requester while others wait (>=1)

Ports:
clk  in  1  system clock (clk_25M175); one clock domain, all logic on its rising edge
rst  in  1  asynchronous, active-high reset
req_valid  in  N  requester i has a pixel write pending
req_addr  in  N*ADDR_WIDTH  packed write addresses; requester i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH]
req_data  in  N  pixel value per requester
req_ready  out  N  one-hot-or-zero grant; a transfer occurs when req_valid[i] & req_ready[i]
hold  in  1  when high, stall all transfers (e.g. around buffer swap)
write_enable  out  1  to frame_buffer
write_addr  out  ADDR_WIDTH  to frame_buffer
write_data  out  1  to frame_buffer
busy  out  1  high when any req_valid is high or write_enable is high

Behaviour:
- Reset (async, rst=1): owner=N-1, burst_cnt=0, write_enable=0, write_addr=0, write_data=0. req_ready is 0 while rst is high.
- Grant selection is combinational from current state and inputs:
  - hold=1 or no valid requester: req_ready=0.
  - Else if req_valid[owner] and burst_cnt<BURST_LEN: grant owner.
  - Else grant the first valid index searching owner+1, owner+2, … modulo N. The owner itself is considered last.
  - When the owner is the only valid requester, it is granted even at burst_cnt==BURST_LEN, and burst_cnt saturates and does not wrap.
- At most one req_ready bit is high. req_ready[i] never asserts without req_valid[i].
- On a transfer by requester g:
  - If g==owner: burst_cnt<=min(burst_cnt+1, BURST_LEN).
  - Else: owner<=g, burst_cnt<=1.
- No transfer: owner and burst_cnt hold. If the owner drops valid, the next grant rotates per the search order; burst_cnt is reset to 1 on the new owner's first transfer.
- Output stage, latency 1 cycle from handshake:
  - write_enable<=transfer, write_addr<=req_addr[g], write_data<=req_data[g].
  - With no transfer: write_enable<=0, write_addr<=0, write_data<=0. Zeros are forced so downstream OR logic stays safe.
- Throughput: one pixel per cycle sustained. There are no bubbles on an owner change.
- hold asserted mid-burst: transfers stop the same cycle and owner/burst_cnt are preserved. On release the owner resumes if still valid and under BURST_LEN.
- Requesters must keep addr/data stable while valid and not ready. The arbiter does not check this.
- Reset asserted mid-transfer: outputs clear immediately (async). An in-flight write is dropped, and the requester retries after reset.

Test Plan:
- Reset: rst=1 with all req_valid=1 -> write_enable=0, req_ready=3'b000. After release, the first grant is requester 0 (owner reset to 2, search starts at 0).
- Single requester: only req_valid[1]=1, addr 100..119 on consecutive cycles -> 20 back-to-back writes, write_addr 100..119, each 1 cycle after its handshake. burst_cnt saturates at 16 and the grant never drops.
- Contention with BURST_LEN=4: all three valid continuously -> grant pattern 0,0,0,0,1,1,1,1,2,2,2,2,0…. write_enable stays high every cycle.
- Hold: assert hold for 5 cycles during requester 2's 2nd beat -> req_ready=0 and write_enable=0 (one cycle later) for 5 cycles. Requester 2 then completes beats 3–4 before rotating to 0.
- Owner drops valid: requester 0 drops after 2 beats while 1 is valid -> requester 1 is granted the next cycle with no idle cycle, and burst_cnt=1.
- Async reset mid-stream: rst pulses between clock edges during a burst -> write_enable falls without waiting for a clock edge. After release, arbitration restarts at requester 0 and busy tracks req_valid.

Source files
------------

// File: rtl/fb_write_arbiter.sv
// Round-robin, burst-bounded arbiter that merges N pixel writers onto the single
// frame_buffer write port using a valid/ready handshake. The output stage is registered.
module fb_write_arbiter #(
  parameter int N                 = 3,
  parameter int HOR_ACTIVE_PIXELS = 640,
  parameter int VER_ACTIVE_PIXELS = 480,
  parameter int BURST_LEN         = 16,
  localparam int ADDR_WIDTH       = $clog2(HOR_ACTIVE_PIXELS * VER_ACTIVE_PIXELS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N-1:0]            req_valid,
  input  logic [N*ADDR_WIDTH-1:0] req_addr,
  input  logic [N-1:0]            req_data,
  output logic [N-1:0]            req_ready,
  input  logic                    hold,
  output logic                    write_enable,
  output logic [ADDR_WIDTH-1:0]   write_addr,
  output logic                    write_data,
  output logic                    busy
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int CNT_W = $clog2(BURST_LEN + 1);

  logic [IDX_W-1:0]      owner;
  logic [CNT_W-1:0]      burst_cnt;

  logic [IDX_W-1:0]      sel_p0;
  logic [IDX_W-1:0]      idx;
  logic                  xfer_p0;
  logic [ADDR_WIDTH-1:0] addr_p0;
  logic                  data_p0;

  // Stage p0: combinational grant from owner/burst state and live requests.
  // burst_cnt==0 only occurs straight after reset, meaning no burst is in progress,
  // so the owner does not get priority and the search starts at owner+1.
  always_comb begin
    sel_p0  = owner;
    xfer_p0 = 1'b0;
    idx     = owner;
    if (!rst && !hold) begin
      if (req_valid[owner] && (burst_cnt != '0) && (burst_cnt < CNT_W'(BURST_LEN))) begin
        sel_p0  = owner;
        xfer_p0 = 1'b1;
      end else begin
        for (int k = 1; k <= N; k++) begin
          idx = IDX_W'((int'(owner) + k) % N);
          if (!xfer_p0 && req_valid[idx]) begin
            sel_p0  = idx;
            xfer_p0 = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < N; i++)
      req_ready[i] = xfer_p0 && (sel_p0 == IDX_W'(i));
  end

  assign addr_p0 = req_addr[int'(sel_p0) * ADDR_WIDTH +: ADDR_WIDTH];
  assign data_p0 = req_data[sel_p0];

  // Stage p1: arbitration state update and registered write port (zeros when idle).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner        <= IDX_W'(N - 1);
      burst_cnt    <= '0;
      write_enable <= 1'b0;
      write_addr   <= '0;
      write_data   <= 1'b0;
    end else begin
      write_enable <= xfer_p0;
      write_addr   <= xfer_p0 ? addr_p0 : '0;
      write_data   <= xfer_p0 ? data_p0 : 1'b0;
      if (xfer_p0) begin
        if (sel_p0 == owner) begin
          if (burst_cnt < CNT_W'(BURST_LEN))
            burst_cnt <= burst_cnt + CNT_W'(1);
        end else begin
          owner     <= sel_p0;
          burst_cnt <= CNT_W'(1);
        end
      end
    end
  end

  assign busy = (|req_valid) | write_enable;

endmodule
